adder_bist: RTL and testbench

Synthesizable built-in self-test engine for the prefix-adder family. It drives an N-bit adder under test with pseudo-random or exhaustive operand pairs and compares each sum against an internal reference `A + B`. It counts mismatches and reports pass/fail through a start/done handshake. It supports combinational and pipelined DUTs, so adder variants can be checked on the FPGA itself, not only in simulation.

---
 rtl/adder_bist_if.sv | 47 ++++
 rtl/adder_bist.sv | 215 +++++++++++++++++++++
 tb/tb_adder_bist.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_bist_if.sv
// adder_bist_if: bundle between the adder BIST engine and its environment.
//   Parameter N   : operand width.
//   start, mode   : run request and mode select (0 random, 1 exhaustive).
//   A, B          : operands presented to the adder under test.
//   S             : N+1-bit sum returned by the adder under test.
//   busy, done    : run in progress / run finished.
//   pass          : 1 when the finished run saw no mismatch.
//   err_count     : saturating mismatch count.
//   fail_A/B/S    : first-mismatch capture, present only when
//                   ADDER_BIST_CAPTURE_EN is defined.
// Modports: master = BIST engine, slave = environment driving start/mode/S.
interface adder_bist_if #(
    parameter int N = 16
);
    logic         start;
    logic         mode;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N:0]   S;
    logic         busy;
    logic         done;
    logic         pass;
    logic [31:0]  err_count;
`ifdef ADDER_BIST_CAPTURE_EN
    logic [N-1:0] fail_A;
    logic [N-1:0] fail_B;
    logic [N:0]   fail_S;

    modport master (
        input  start, mode, S,
        output A, B, busy, done, pass, err_count, fail_A, fail_B, fail_S
    );
    modport slave (
        output start, mode, S,
        input  A, B, busy, done, pass, err_count, fail_A, fail_B, fail_S
    );
`else
    modport master (
        input  start, mode, S,
        output A, B, busy, done, pass, err_count
    );
    modport slave (
        output start, mode, S,
        input  A, B, busy, done, pass, err_count
    );
`endif
endinterface

// File: rtl/adder_bist.sv
// adder_bist: built-in self-test engine for N-bit adders.
// Drives random (two Galois LFSRs) or exhaustive operand pairs on A/B, one per
// cycle, and compares the DUT sum S against A+B delayed LAT cycles. Mismatches
// (including X/Z on S) are counted with saturation; pass/done report the result.
// Ports:
//   clk       : clock.
//   rst       : synchronous active-high reset.
//   bus       : adder_bist_if.master (start, mode, A, B, S, busy, done, pass,
//               err_count, and fail_A/fail_B/fail_S with ADDER_BIST_CAPTURE_EN).
// Parameters: N (width), T (random vectors per run), LAT (DUT latency 0..4),
//   SEED (nonzero LFSR seed).
// Optional feature macro: ADDER_BIST_CAPTURE_EN captures the first mismatch.
module adder_bist #(
    parameter int          N    = 16,
    parameter int unsigned T    = 1024,
    parameter int          LAT  = 0,
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input logic          clk,
    input logic          rst,
    adder_bist_if.master bus
);
    localparam logic [31:0]     POLY       = 32'h8020_0003;
    localparam int unsigned     DEPTH      = (LAT == 0) ? 1 : LAT;
    localparam int unsigned     TAP        = (LAT == 0) ? 0 : LAT - 1;
    localparam logic [31:0]     EXH_LAST   = (N <= 12) ? 32'((64'd1 << (2 * N)) - 64'd1) : 32'd0;
    localparam logic [31:0]     RND_LAST   = 32'(T - 1);
    localparam logic [2:0]      DRAIN_LAST = 3'(DEPTH - 1);
    localparam logic [2*N-1:0]  CNT_ONE    = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state;
    logic [N-1:0]   a_q, b_q;
    logic           busy_q, done_q, pass_q;
    logic [31:0]    err_q, err_next;
    logic           mode_q;
    logic [31:0]    lfsr_a, lfsr_b;
    logic [2*N-1:0] cnt;
    logic [31:0]    remain;
    logic [2:0]     drain_cnt;

    logic [N:0]     exp_pipe [DEPTH];
    logic           vld_pipe [DEPTH];
    logic           cur_vld, cmp_vld, mismatch;
    logic [N:0]     cur_exp, cmp_exp;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    endfunction

    // A/B hold a live vector exactly while in RUN.
    always_comb begin
        cur_vld = (state == RUN);
        cur_exp = {1'b0, a_q} + {1'b0, b_q};
        if (LAT == 0) begin
            cmp_vld = cur_vld;
            cmp_exp = cur_exp;
        end else begin
            cmp_vld = vld_pipe[TAP];
            cmp_exp = exp_pipe[TAP];
        end
        mismatch = cmp_vld && (bus.S !== cmp_exp);
        err_next = err_q;
        if (mismatch && (err_q != '1)) begin
            err_next = err_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        exp_pipe[0] <= cur_exp;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            exp_pipe[i] <= exp_pipe[i-1];
        end
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                vld_pipe[i] <= 1'b0;
            end
        end else begin
            vld_pipe[0] <= cur_vld;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            mode_q    <= 1'b0;
            lfsr_a    <= SEED;
            lfsr_b    <= ~SEED;
            cnt       <= '0;
            remain    <= '0;
            drain_cnt <= '0;
        end else begin
            err_q <= err_next;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        // Generators are reloaded and vector 0 is issued on the
                        // same edge, so the stored generator state is one step ahead.
                        state  <= RUN;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        pass_q <= 1'b0;
                        err_q  <= '0;
                        mode_q <= bus.mode;
                        remain <= bus.mode ? EXH_LAST : RND_LAST;
                        lfsr_a <= lfsr_step(SEED);
                        lfsr_b <= lfsr_step(~SEED);
                        cnt    <= CNT_ONE;
                        if (bus.mode) begin
                            a_q <= '0;
                            b_q <= '0;
                        end else begin
                            a_q <= SEED[N-1:0];
                            b_q <= ~SEED[N-1:0];
                        end
                    end
                end
                RUN: begin
                    if (remain == '0) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LAST;
                    end else begin
                        remain <= remain - 32'd1;
                        if (mode_q) begin
                            a_q <= cnt[2*N-1:N];
                            b_q <= cnt[N-1:0];
                            cnt <= cnt + CNT_ONE;
                        end else begin
                            a_q    <= lfsr_a[N-1:0];
                            b_q    <= lfsr_b[N-1:0];
                            lfsr_a <= lfsr_step(lfsr_a);
                            lfsr_b <= lfsr_step(lfsr_b);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        // The last compare lands on this same edge.
                        pass_q <= (err_next == '0);
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;

`ifdef ADDER_BIST_CAPTURE_EN
    logic [N-1:0] opa_pipe [DEPTH];
    logic [N-1:0] opb_pipe [DEPTH];
    logic [N-1:0] cmp_a, cmp_b;
    logic [N-1:0] fail_a_q, fail_b_q;
    logic [N:0]   fail_s_q;
    logic         start_ok;

    // Operands travel with the expected sum so the capture matches the
    // vector actually being compared.
    always_ff @(posedge clk) begin
        opa_pipe[0] <= a_q;
        opb_pipe[0] <= b_q;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            opa_pipe[i] <= opa_pipe[i-1];
            opb_pipe[i] <= opb_pipe[i-1];
        end
    end

    always_comb begin
        start_ok = bus.start && ((state == IDLE) || (state == DONE));
        if (LAT == 0) begin
            cmp_a = a_q;
            cmp_b = b_q;
        end else begin
            cmp_a = opa_pipe[TAP];
            cmp_b = opb_pipe[TAP];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            fail_a_q <= '0;
            fail_b_q <= '0;
            fail_s_q <= '0;
        end else if (mismatch && (err_q == '0)) begin
            fail_a_q <= cmp_a;
            fail_b_q <= cmp_b;
            fail_s_q <= bus.S;
        end
    end

    assign bus.fail_A = fail_a_q;
    assign bus.fail_B = fail_b_q;
    assign bus.fail_S = fail_s_q;
`endif
endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: directed, table-driven bench for adder_bist.
// Five engine instances, each paired with a small adder model:
//   u0 golden comb N=16 T=1000 LAT=0; u1 2-stage with S[0]=0, N=4 LAT=2;
//   u2/u3 golden 2-stage, N=8 T=100, LAT=1 (misaligned) / LAT=2;
//   u4 comb with carry-out tied low, N=8 LAT=0.
module tb_adder_bist;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0]  start_v, mode_v, done_v, busy_v, pass_v;
    logic [31:0] err_v [5];
    int n_run = 0;
    int n_fail = 0;

    adder_bist_if #(.N(16)) b0 ();
    adder_bist_if #(.N(4))  b1 ();
    adder_bist_if #(.N(8))  b2 ();
    adder_bist_if #(.N(8))  b3 ();
    adder_bist_if #(.N(8))  b4 ();

    adder_bist #(.N(16), .T(1000), .LAT(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    adder_bist #(.N(4),  .T(1024), .LAT(2)) u1 (.clk(clk), .rst(rst), .bus(b1));
    adder_bist #(.N(8),  .T(100),  .LAT(1)) u2 (.clk(clk), .rst(rst), .bus(b2));
    adder_bist #(.N(8),  .T(100),  .LAT(2)) u3 (.clk(clk), .rst(rst), .bus(b3));
    adder_bist #(.N(8),  .T(1024), .LAT(0)) u4 (.clk(clk), .rst(rst), .bus(b4));

    assign b0.start = start_v[0]; assign b0.mode = mode_v[0];
    assign b1.start = start_v[1]; assign b1.mode = mode_v[1];
    assign b2.start = start_v[2]; assign b2.mode = mode_v[2];
    assign b3.start = start_v[3]; assign b3.mode = mode_v[3];
    assign b4.start = start_v[4]; assign b4.mode = mode_v[4];

    assign done_v = {b4.done, b3.done, b2.done, b1.done, b0.done};
    assign busy_v = {b4.busy, b3.busy, b2.busy, b1.busy, b0.busy};
    assign pass_v = {b4.pass, b3.pass, b2.pass, b1.pass, b0.pass};
    assign err_v[0] = b0.err_count;
    assign err_v[1] = b1.err_count;
    assign err_v[2] = b2.err_count;
    assign err_v[3] = b3.err_count;
    assign err_v[4] = b4.err_count;

    // Adder models.
    logic [4:0] p1a, p1b;
    logic [8:0] p2a, p2b, p3a, p3b, sum4;
    always @(posedge clk) begin
        p1a <= {1'b0, b1.A} + {1'b0, b1.B};
        p1b <= p1a;
        p2a <= {1'b0, b2.A} + {1'b0, b2.B};
        p2b <= p2a;
        p3a <= {1'b0, b3.A} + {1'b0, b3.B};
        p3b <= p3a;
    end
    assign b0.S = {1'b0, b0.A} + {1'b0, b0.B};
    assign b1.S = {p1b[4:1], 1'b0};
    assign b2.S = p2b;
    assign b3.S = p3b;
    assign sum4 = {1'b0, b4.A} + {1'b0, b4.B};
    assign b4.S = {1'b0, sum4[7:0]};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input logic [31:0] act,
                               input int unsigned lo, input int unsigned hi);
        n_run++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Counts edges from the current point until done is seen (#1 after an edge).
    task automatic wait_done(input int k, output int cyc);
        cyc = 0;
        while (cyc < 70000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_v[k]) break;
        end
        if (!done_v[k]) begin
            n_run++;
            n_fail++;
            $display("FAIL done_timeout u%0d: got done=0 expected done=1", k);
        end
    endtask

    task automatic launch(input int k, input logic m);
        @(negedge clk);
        start_v[k] = 1'b1;
        mode_v[k]  = m;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          k;
        logic        m;
        int          cyc;
        int unsigned err_lo;
        int unsigned err_hi;
        logic        pass;
    } vec_t;

    vec_t tbl [5];
    int   cyc;

    initial begin
        tbl[0] = '{"golden_rand16",   0, 1'b0, 1001,  0,     0,     1'b1};
        tbl[1] = '{"s0stuck_exh4",    1, 1'b1, 258,   128,   128,   1'b0};
        tbl[2] = '{"misaligned_lat1", 2, 1'b0, 101,   1,     100,   1'b0};
        tbl[3] = '{"aligned_lat2",    3, 1'b0, 102,   0,     0,     1'b1};
        tbl[4] = '{"carry_exh8",      4, 1'b1, 65537, 32640, 32640, 1'b0};

        start_v = '0;
        mode_v  = '0;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_A",    64'(b0.A), 0);
        check("rst_B",    64'(b0.B), 0);
        check("rst_busy", 64'(busy_v[0]), 0);
        check("rst_done", 64'(done_v[0]), 0);
        check("rst_pass", 64'(pass_v[0]), 0);
        check("rst_err",  64'(err_v[0]), 0);
        @(negedge clk);
        rst = 1'b0;

        // Random-mode first vectors: SEED and ~SEED, then one Galois step each.
        launch(0, 1'b0);
        check("u0_busy_rise", 64'(busy_v[0]), 1);
        check("u0_vec0_A", 64'(b0.A), 64'h2468);
        check("u0_vec0_B", 64'(b0.B), 64'hDB97);
        @(posedge clk);
        #1;
        check("u0_vec1_A", 64'(b0.A), 64'h9234);
        check("u0_vec1_B", 64'(b0.B), 64'h6DC8);
        wait_done(0, cyc);
        check("u0_first_cycles", 64'(cyc + 1), 1001);

        // Exhaustive first vectors: counter 0 then 1 in the low (B) half.
        launch(1, 1'b1);
        check("u1_vec0_AB", 64'({b1.A, b1.B}), 0);
        @(posedge clk);
        #1;
        check("u1_vec1_AB", 64'({b1.A, b1.B}), 1);
        wait_done(1, cyc);
        check("u1_first_cycles", 64'(cyc + 1), 258);

        for (int i = 0; i < 5; i++) begin
            launch(tbl[i].k, tbl[i].m);
            wait_done(tbl[i].k, cyc);
            check({tbl[i].name, "_cycles"}, 64'(cyc), 64'(tbl[i].cyc));
            if (tbl[i].err_lo == tbl[i].err_hi)
                check({tbl[i].name, "_err"}, 64'(err_v[tbl[i].k]), 64'(tbl[i].err_lo));
            else
                check_range({tbl[i].name, "_err"}, err_v[tbl[i].k], tbl[i].err_lo, tbl[i].err_hi);
            check({tbl[i].name, "_pass"}, 64'(pass_v[tbl[i].k]), 64'(tbl[i].pass));
            check({tbl[i].name, "_busy"}, 64'(busy_v[tbl[i].k]), 0);
        end

`ifdef ADDER_BIST_CAPTURE_EN
        check("cap_fail_A", 64'(b1.fail_A), 0);
        check("cap_fail_B", 64'(b1.fail_B), 1);
        check("cap_fail_S", 64'(b1.fail_S), 0);
`endif

        // Reset mid-run at RUN cycle 50, then a clean rerun.
        launch(1, 1'b1);
        repeat (50) @(posedge clk);
        #1;
        check("mid_err_before_rst", 64'(err_v[1]), 24);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_A",    64'(b1.A), 0);
        check("mid_rst_B",    64'(b1.B), 0);
        check("mid_rst_busy", 64'(busy_v[1]), 0);
        check("mid_rst_done", 64'(done_v[1]), 0);
        check("mid_rst_pass", 64'(pass_v[1]), 0);
        check("mid_rst_err",  64'(err_v[1]), 0);
`ifdef ADDER_BIST_CAPTURE_EN
        check("mid_rst_fail_B", 64'(b1.fail_B), 0);
`endif
        launch(1, 1'b1);
        wait_done(1, cyc);
        check("rerun_cycles", 64'(cyc), 258);
        check("rerun_err",    64'(err_v[1]), 128);

        // start held high: ignored while busy, restarts from DONE.
        @(negedge clk);
        start_v[1] = 1'b1;
        mode_v[1]  = 1'b1;
        @(posedge clk);
        #1;
        wait_done(1, cyc);
        check("held_cycles", 64'(cyc), 258);
        check("held_err",    64'(err_v[1]), 128);
        @(posedge clk);
        #1;
        check("held_restart_busy", 64'(busy_v[1]), 1);
        check("held_restart_done", 64'(done_v[1]), 0);
        check("held_restart_err",  64'(err_v[1]), 0);
        start_v[1] = 1'b0;
        wait_done(1, cyc);
        check("held2_cycles", 64'(cyc), 258);
        check("held2_err",    64'(err_v[1]), 128);
        check("held2_pass",   64'(pass_v[1]), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
